// File: rtl/debug_rom_arb_pkg.sv
// rtl/debug_rom_arb_pkg.sv - shared types, defaults and address helpers for the debug ROM arbiter
package debug_rom_arb_pkg;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int DefRomWords      = 19;
  localparam int DefLockMaxCycles = 16;

  // Byte address layout: [2:0] offset in word, [7:3] word index, [63:8] must be zero
  localparam int AddrOffMsb  = 2;
  localparam int WordIdxLsb  = 3;
  localparam int WordIdxMsb  = 7;
  localparam int AddrHiLsb   = 8;

  function automatic logic addr_in_rom(input logic [63:0] addr, input int unsigned words);
    return (addr[AddrOffMsb:0] == '0) &&
           (32'(addr[WordIdxMsb:WordIdxLsb]) < words) &&
           (addr[63:AddrHiLsb] == '0);
  endfunction

endpackage

// File: rtl/debug_rom_rr_arb.sv
// rtl/debug_rom_rr_arb.sv - round-robin pick: first requester at or after the pointer wins
module debug_rom_rr_arb #(
  parameter int NumReq = 2
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [NumReq-1:0]         gnt_o
);

  int idx;

  // Scan from the farthest offset down so the nearest requester is the last write
  always_comb begin
    gnt_o = '0;
    idx   = 0;
    for (int off = NumReq - 1; off >= 0; off--) begin
      idx = (int'(ptr_i) + off) % NumReq;
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_rom_arb.sv
// rtl/debug_rom_arb.sv - arbitrates requesters onto a single-cycle-latency debug ROM with optional lock
module debug_rom_arb
  import debug_rom_arb_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int RomWords      = DefRomWords,
  parameter int LockMaxCycles = DefLockMaxCycles
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0]        lock_i,
  input  logic [NumReq-1:0][63:0]  addr_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [63:0]              rdata_o,
  output logic                     err_o,
  output logic                     rom_req_o,
  output logic [63:0]              rom_addr_o,
  input  logic [63:0]              rom_rdata_i
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(LockMaxCycles + 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NumReq-1:0]   inhibit_q, inhibit_d;
  logic                rvalid_q, rvalid_d;
  logic [IdxW-1:0]     rsp_idx_q, rsp_idx_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NumReq-1:0]   rr_gnt;
  logic [IdxW-1:0]     gnt_idx;
  logic                gnt_any;
  logic [63:0]         sel_addr;
  logic                addr_ok;

  debug_rom_rr_arb #(.NumReq(NumReq)) u_rr_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_ARB;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      inhibit_q <= '0;
      rvalid_q  <= 1'b0;
      rsp_idx_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      inhibit_q <= inhibit_d;
      rvalid_q  <= rvalid_d;
      rsp_idx_q <= rsp_idx_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    // A forced-out owner may lock again only after it has dropped lock_i once
    inhibit_d = inhibit_q & lock_i;
    rvalid_d  = gnt_any;
    rsp_idx_d = gnt_idx;
    rsp_err_d = !addr_ok;
    if (gnt_any) begin
      ptr_d = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
    end
    case (state_q)
      ST_ARB: begin
        if (gnt_any && lock_i[gnt_idx] && !inhibit_q[gnt_idx]) begin
          state_d = ST_LOCKED;
          owner_d = gnt_idx;
          cnt_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (req_i[owner_q]) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!req_i[owner_q] || !lock_i[owner_q]) begin
          state_d = ST_ARB;
        end else if (cnt_d == CntW'(LockMaxCycles)) begin
          state_d            = ST_ARB;
          inhibit_d[owner_q] = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    gnt_o = '0;
    if (!rst_i) begin
      if (state_q == ST_ARB) begin
        gnt_o = rr_gnt;
      end else if (req_i[owner_q]) begin
        gnt_o[owner_q] = 1'b1;
      end
    end
    gnt_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_o[i]) gnt_idx = IdxW'(i);
    end
    gnt_any    = |gnt_o;
    sel_addr   = addr_i[gnt_idx];
    addr_ok    = addr_in_rom(sel_addr, RomWords);
    rom_req_o  = gnt_any && addr_ok;
    rom_addr_o = gnt_any ? sel_addr : '0;

    rvalid_o = '0;
    if (!rst_i && rvalid_q) rvalid_o[rsp_idx_q] = 1'b1;
    err_o   = !rst_i && rvalid_q && rsp_err_q;
    rdata_o = (!rst_i && rvalid_q && !rsp_err_q) ? rom_rdata_i : '0;
  end

endmodule

// File: tb/tb_debug_rom_arb.sv
// tb/tb_debug_rom_arb.sv - self-checking bench for debug_rom_arb against a grant/lock reference model
module tb_debug_rom_arb;

  localparam int N  = 2;
  localparam int RW = 19;
  localparam int LM = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req, lock;
  logic [N-1:0][63:0]   addr;
  logic [N-1:0]         gnt_o, rvalid_o;
  logic [63:0]          rdata_o, rom_addr_o, rom_rdata;
  logic                 err_o, rom_req_o;
  logic [63:0]          rom_mem [32];

  int checks = 0;
  int errors = 0;

  // reference model state: last granted port, lock owner (-1 none), grants in current locked run
  int m_last = N - 1;
  int m_owner = -1;
  int m_run = 0;
  bit m_blocked [N];
  bit p_v = 1'b0;
  int p_idx = 0;
  bit p_err = 1'b0;
  int p_word = 0;
  int mg = -1;
  logic [N-1:0] obs_gnt;

  always #5 clk = ~clk;

  debug_rom_arb #(.NumReq(N), .RomWords(RW), .LockMaxCycles(LM)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .lock_i      (lock),
    .addr_i      (addr),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .rom_req_o   (rom_req_o),
    .rom_addr_o  (rom_addr_o),
    .rom_rdata_i (rom_rdata)
  );

  always @(posedge clk) begin
    if (rom_req_o) rom_rdata <= rom_mem[rom_addr_o[7:3]];
    else           rom_rdata <= {$urandom, $urandom};
  end

  function automatic bit addr_ok(input logic [63:0] a);
    return (a % 64'd8 == 64'd0) && (a < 64'(RW * 8));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int g;
    logic [N-1:0] eg, ev;
    #4;
    g = -1;
    if (!rst) begin
      if (m_owner >= 0) begin
        if (req[m_owner]) g = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && req[(m_last + k) % N]) g = (m_last + k) % N;
        end
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("gnt", 64'(gnt_o), 64'(eg));
    check("rom_req", 64'(rom_req_o), 64'(g >= 0 && addr_ok(addr[g])));
    if (g >= 0 && addr_ok(addr[g])) check("rom_addr", rom_addr_o, addr[g]);
    ev = '0;
    if (!rst && p_v) ev[p_idx] = 1'b1;
    check("rvalid", 64'(rvalid_o), 64'(ev));
    check("err", 64'(err_o), 64'(!rst && p_v && p_err));
    check("rdata", rdata_o, (!rst && p_v && !p_err) ? rom_mem[p_word] : 64'd0);
    obs_gnt = gnt_o;
    @(posedge clk);
    #1;
    mg = g;
    if (rst) begin
      m_last = N - 1;
      m_owner = -1;
      m_run = 0;
      for (int i = 0; i < N; i++) m_blocked[i] = 1'b0;
      p_v = 1'b0;
    end else begin
      p_v = (g >= 0);
      if (g >= 0) begin
        p_idx = g;
        p_err = !addr_ok(addr[g]);
        p_word = int'(addr[g][7:3]);
      end
      if (m_owner >= 0) begin
        if (g < 0) m_owner = -1;
        else begin
          m_run++;
          if (!lock[m_owner]) m_owner = -1;
          else if (m_run == LM + 1) begin
            m_blocked[m_owner] = 1'b1;
            m_owner = -1;
          end
        end
      end else if (g >= 0 && lock[g] && !m_blocked[g]) begin
        m_owner = g;
        m_run = 1;
      end
      for (int i = 0; i < N; i++) if (!lock[i]) m_blocked[i] = 1'b0;
      if (g >= 0) m_last = g;
    end
  endtask

  initial begin
    logic [N-1:0] seq [4];
    int run;
    bit done;
    logic [N-1:0] first_other;
    logic [63:0] a;

    for (int i = 0; i < 32; i++) rom_mem[i] = {$urandom, $urandom};
    rst = 1'b1; req = 2'b11; lock = '0; addr = '0;
    @(posedge clk);
    #1;

    // reset recovery
    repeat (3) begin
      cycle();
      check("rst_gnt", 64'(obs_gnt), 64'd0);
    end
    rst = 1'b0; addr[0] = 64'h08; addr[1] = 64'h08;
    for (int k = 0; k < 4; k++) begin
      cycle();
      seq[k] = obs_gnt;
    end
    check("rr_first", 64'(seq[0]), 64'b01);
    check("rr_second", 64'(seq[1]), 64'b10);
    check("rr_third", 64'(seq[2]), 64'b01);
    check("rr_fourth", 64'(seq[3]), 64'b10);
    req = '0;
    cycle();

    // error responses: word 19 and misaligned
    req = 2'b01; addr[0] = 64'h98;
    cycle();
    addr[0] = 64'h0C;
    cycle();
    req = '0;
    cycle();

    // lock timeout
    rst = 1'b1;
    cycle();
    rst = 1'b0; req = 2'b11; lock = 2'b01; addr[0] = 64'h10; addr[1] = 64'h18;
    run = 0; done = 1'b0; first_other = '0;
    for (int k = 0; k < 24; k++) begin
      cycle();
      if (!done) begin
        if (obs_gnt == 2'b01) run++;
        else begin
          done = 1'b1;
          first_other = obs_gnt;
        end
      end
    end
    check("lock_run", 64'(run), 64'd17);
    check("lock_next", 64'(first_other), 64'b10);
    lock = '0;
    cycle();
    lock = 2'b01;
    repeat (4) cycle();

    // reset mid-transaction
    req = '0; lock = '0;
    cycle();
    req = 2'b01; addr[0] = 64'h20;
    cycle();
    rst = 1'b1; req = '0;
    cycle();
    rst = 1'b0; req = 2'b11; addr[1] = 64'h28;
    cycle();
    check("post_rst_gnt", 64'(obs_gnt), 64'b01);

    // randomized traffic, honouring hold-until-granted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) lock[i] = ~lock[i];
        if (!(req[i] && mg != i)) begin
          req[i] = 1'($urandom_range(0, 1));
          a = 64'($urandom_range(0, 23)) * 64'd8;
          case ($urandom_range(0, 9))
            0: a = a + 64'd4;
            1: a = a | (64'd1 << $urandom_range(8, 63));
            default: ;
          endcase
          addr[i] = a;
        end
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
